id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS pipeline. It consumes the IF/ID register outputs (PC, instruction) and holds the 32x32 register file.
- Generates main control, resolves beq/bne/j in ID, and detects load-use and branch-operand hazards.
- Drives the registered ID/EX pipeline bundle consumed by the EX stage.
- Returns PCSrc/BranchPC to the fetch stage, plus Stall/IfFlush for the PC register and IF/ID register.

---
 rtl/id_stage.sv | 192 +++++++++++++++++++
 tb/tb_id_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// MIPS decode stage: main control, 32x32 register file with WB bypass, branch/jump
// resolution in ID, load-use and branch-operand hazard detection, and the ID/EX register.
module id_stage (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [31:0] IfPc,
   input  logic [31:0] IfInstr,
   input  logic        WbRegWrite,
   input  logic [4:0]  WbWriteReg,
   input  logic [31:0] WbWriteData,
   input  logic        MemRegWrite,
   input  logic [4:0]  MemWriteReg,
   output logic        PCSrc,
   output logic [31:0] BranchPC,
   output logic        Stall,
   output logic        IfFlush,
   output logic [31:0] IdExPc,
   output logic [31:0] IdExRdData1,
   output logic [31:0] IdExRdData2,
   output logic [31:0] IdExImm,
   output logic [4:0]  IdExRs,
   output logic [4:0]  IdExRt,
   output logic [4:0]  IdExRd,
   output logic        IdExRegWrite,
   output logic        IdExMemToReg,
   output logic        IdExMemRead,
   output logic        IdExMemWrite,
   output logic        IdExALUSrc,
   output logic        IdExRegDst,
   output logic [1:0]  IdExALUOp
);

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_BEQ   = 6'h04,
      OP_BNE   = 6'h05,
      OP_ADDI  = 6'h08,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2B
   } opcode_e;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       reg_dst;
      logic [1:0] alu_op;
   } ctrl_t;

   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_ext;
   logic [31:0] pc_plus4;
   logic [31:0] rd_data1, rd_data2;
   logic [31:0] regs [32];
   ctrl_t       ctrl;
   logic        is_beq, is_bne, is_j;
   logic        taken;
   logic        load_use, branch_hazard;
   logic [4:0]  dest_ex;

   assign opcode   = IfInstr[31:26];
   assign rs       = IfInstr[25:21];
   assign rt       = IfInstr[20:16];
   assign rd       = IfInstr[15:11];
   assign imm_ext  = {{16{IfInstr[15]}}, IfInstr[15:0]};
   assign pc_plus4 = IfPc + 32'd4;

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      ctrl   = '0;
      is_beq = 1'b0;
      is_bne = 1'b0;
      is_j   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
            ctrl.alu_op    = 2'b10;
         end
         OP_LW: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.alu_src    = 1'b1;
         end
         OP_SW: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
         end
         OP_ADDI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
         end
         OP_BEQ: begin
            ctrl.alu_op = 2'b01;
            is_beq      = 1'b1;
         end
         OP_BNE: begin
            ctrl.alu_op = 2'b01;
            is_bne      = 1'b1;
         end
         OP_J:    is_j = 1'b1;
         default: ;
      endcase
   end

   // NOTE: the register array is reset like any other state, so it lives in an
   // async-reset flop block rather than an inferred RAM macro.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (WbRegWrite && WbWriteReg != 5'd0) begin
         regs[WbWriteReg] <= WbWriteData;
      end
   end

   // Write-through: a same-cycle WB write to the addressed register wins.
   assign rd_data1 = (rs == 5'd0) ? 32'd0 :
                     (WbRegWrite && WbWriteReg == rs) ? WbWriteData : regs[rs];
   assign rd_data2 = (rt == 5'd0) ? 32'd0 :
                     (WbRegWrite && WbWriteReg == rt) ? WbWriteData : regs[rt];

   assign dest_ex  = IdExRegDst ? IdExRd : IdExRt;

   assign load_use = IdExMemRead && IdExRt != 5'd0 && (IdExRt == rs || IdExRt == rt);

   // Branches compare in ID, so any producer still in EX or MEM must drain to WB first.
   assign branch_hazard = (is_beq || is_bne) &&
                          ((IdExRegWrite && dest_ex != 5'd0 && (dest_ex == rs || dest_ex == rt)) ||
                           (MemRegWrite && MemWriteReg != 5'd0 &&
                            (MemWriteReg == rs || MemWriteReg == rt)));

   assign Stall = load_use || branch_hazard;

   assign taken = (is_beq && rd_data1 == rd_data2) ||
                  (is_bne && rd_data1 != rd_data2) ||
                  is_j;

   assign BranchPC = is_j ? {pc_plus4[31:28], IfInstr[25:0], 2'b00}
                          : pc_plus4 + {imm_ext[29:0], 2'b00};
   assign PCSrc    = taken && !Stall;
   assign IfFlush  = PCSrc;

   // NOTE: sequential state uses non-blocking assignments so all flops sample together.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         IdExPc       <= '0;
         IdExRdData1  <= '0;
         IdExRdData2  <= '0;
         IdExImm      <= '0;
         IdExRs       <= '0;
         IdExRt       <= '0;
         IdExRd       <= '0;
         IdExRegWrite <= 1'b0;
         IdExMemToReg <= 1'b0;
         IdExMemRead  <= 1'b0;
         IdExMemWrite <= 1'b0;
         IdExALUSrc   <= 1'b0;
         IdExRegDst   <= 1'b0;
         IdExALUOp    <= 2'b00;
      end else if (Stall) begin
         // Bubble: controls cleared, data fields simply hold.
         IdExRegWrite <= 1'b0;
         IdExMemToReg <= 1'b0;
         IdExMemRead  <= 1'b0;
         IdExMemWrite <= 1'b0;
         IdExALUSrc   <= 1'b0;
         IdExRegDst   <= 1'b0;
         IdExALUOp    <= 2'b00;
      end else begin
         IdExPc       <= IfPc;
         IdExRdData1  <= rd_data1;
         IdExRdData2  <= rd_data2;
         IdExImm      <= imm_ext;
         IdExRs       <= rs;
         IdExRt       <= rt;
         IdExRd       <= rd;
         IdExRegWrite <= ctrl.reg_write;
         IdExMemToReg <= ctrl.mem_to_reg;
         IdExMemRead  <= ctrl.mem_read;
         IdExMemWrite <= ctrl.mem_write;
         IdExALUSrc   <= ctrl.alu_src;
         IdExRegDst   <= ctrl.reg_dst;
         IdExALUOp    <= ctrl.alu_op;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, register file bypass, branch/jump resolution,
// load-use and branch-operand stalls, asynchronous reset.
module tb_id_stage;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic [31:0] IfPc, IfInstr;
   logic        WbRegWrite;
   logic [4:0]  WbWriteReg;
   logic [31:0] WbWriteData;
   logic        MemRegWrite;
   logic [4:0]  MemWriteReg;
   logic        PCSrc, Stall, IfFlush;
   logic [31:0] BranchPC;
   logic [31:0] IdExPc, IdExRdData1, IdExRdData2, IdExImm;
   logic [4:0]  IdExRs, IdExRt, IdExRd;
   logic        IdExRegWrite, IdExMemToReg, IdExMemRead, IdExMemWrite, IdExALUSrc, IdExRegDst;
   logic [1:0]  IdExALUOp;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [31:0] NOP = 32'hFC00_0000;

   id_stage dut (
      .Clk(Clk), .Reset_n(Reset_n), .IfPc(IfPc), .IfInstr(IfInstr),
      .WbRegWrite(WbRegWrite), .WbWriteReg(WbWriteReg), .WbWriteData(WbWriteData),
      .MemRegWrite(MemRegWrite), .MemWriteReg(MemWriteReg),
      .PCSrc(PCSrc), .BranchPC(BranchPC), .Stall(Stall), .IfFlush(IfFlush),
      .IdExPc(IdExPc), .IdExRdData1(IdExRdData1), .IdExRdData2(IdExRdData2), .IdExImm(IdExImm),
      .IdExRs(IdExRs), .IdExRt(IdExRt), .IdExRd(IdExRd),
      .IdExRegWrite(IdExRegWrite), .IdExMemToReg(IdExMemToReg), .IdExMemRead(IdExMemRead),
      .IdExMemWrite(IdExMemWrite), .IdExALUSrc(IdExALUSrc), .IdExRegDst(IdExRegDst),
      .IdExALUOp(IdExALUOp)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
      IfInstr     = NOP;
      WbRegWrite  = 1'b1;
      WbWriteReg  = r;
      WbWriteData = d;
      step();
      WbRegWrite  = 1'b0;
   endtask

   function automatic logic [31:0] r_type(input logic [4:0] s, t, d);
      return {6'h00, s, t, d, 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s, t,
                                          input logic [15:0] imm);
      return {op, s, t, imm};
   endfunction

   initial begin
      Reset_n     = 1'b1;
      IfPc        = 32'h0;
      IfInstr     = NOP;
      WbRegWrite  = 1'b0;
      WbWriteReg  = 5'd0;
      WbWriteData = 32'h0;
      MemRegWrite = 1'b0;
      MemWriteReg = 5'd0;
      #1 Reset_n = 1'b0;
      #2;
      check("reset_regwrite", {31'd0, IdExRegWrite}, 32'd0);
      check("reset_pc", IdExPc, 32'd0);
      check("reset_aluop", {30'd0, IdExALUOp}, 32'd0);
      repeat (2) @(posedge Clk);
      #1 Reset_n = 1'b1;

      wb_write(5'd1, 32'd7);
      wb_write(5'd2, 32'd7);
      wb_write(5'd5, 32'h55);

      // WB bypass into the same-cycle read
      IfPc        = 32'h20;
      IfInstr     = r_type(5'd8, 5'd0, 5'd9);
      WbRegWrite  = 1'b1;
      WbWriteReg  = 5'd8;
      WbWriteData = 32'hDEADBEEF;
      step();
      WbRegWrite  = 1'b0;
      check("bypass_rd1", IdExRdData1, 32'hDEADBEEF);
      check("rtype_regdst", {31'd0, IdExRegDst}, 32'd1);
      check("rtype_aluop", {30'd0, IdExALUOp}, 32'd2);
      check("rtype_rd", {27'd0, IdExRd}, 32'd9);
      check("rtype_pc", IdExPc, 32'h20);

      // Stored read of r8 and r5
      IfInstr = r_type(5'd8, 5'd5, 5'd9);
      step();
      check("stored_rd1", IdExRdData1, 32'hDEADBEEF);
      check("stored_rd2", IdExRdData2, 32'h55);

      // Load-use: lw $2,0($1) ; add $3,$2,$4
      IfInstr = i_type(6'h23, 5'd1, 5'd2, 16'd0);
      step();
      check("lw_memread", {31'd0, IdExMemRead}, 32'd1);
      check("lw_memtoreg", {31'd0, IdExMemToReg}, 32'd1);
      IfInstr = r_type(5'd2, 5'd4, 5'd3);
      #1 check("loaduse_stall", {31'd0, Stall}, 32'd1);
      step();
      check("bubble_regwrite", {31'd0, IdExRegWrite}, 32'd0);
      check("bubble_memread", {31'd0, IdExMemRead}, 32'd0);
      check("loaduse_release", {31'd0, Stall}, 32'd0);
      step();
      check("add_captured", {31'd0, IdExRegWrite}, 32'd1);
      check("add_rd", {27'd0, IdExRd}, 32'd3);

      IfInstr = i_type(6'h2B, 5'd1, 5'd2, 16'd4);
      step();
      check("sw_memwrite", {31'd0, IdExMemWrite}, 32'd1);
      check("sw_alusrc", {31'd0, IdExALUSrc}, 32'd1);
      check("sw_regwrite", {31'd0, IdExRegWrite}, 32'd0);
      check("sw_imm", IdExImm, 32'd4);

      // Branch resolution
      wb_write(5'd2, 32'd7);
      IfPc    = 32'h100;
      IfInstr = i_type(6'h04, 5'd1, 5'd2, 16'd3);
      #1;
      check("beq_pcsrc", {31'd0, PCSrc}, 32'd1);
      check("beq_target", BranchPC, 32'h110);
      check("beq_flush", {31'd0, IfFlush}, 32'd1);
      WbRegWrite  = 1'b1;
      WbWriteReg  = 5'd2;
      WbWriteData = 32'd6;
      #1 check("beq_not_taken", {31'd0, PCSrc}, 32'd0);
      step();
      WbRegWrite = 1'b0;
      IfInstr    = i_type(6'h05, 5'd1, 5'd2, 16'hFFFF);
      #1;
      check("bne_pcsrc", {31'd0, PCSrc}, 32'd1);
      check("bne_target", BranchPC, 32'h100);
      step();
      check("bne_imm", IdExImm, 32'hFFFFFFFF);
      check("bne_aluop", {30'd0, IdExALUOp}, 32'd1);

      // Branch-operand hazard: addi $1,$0,5 ; beq $1,$0,2
      IfInstr = i_type(6'h08, 5'd0, 5'd1, 16'd5);
      step();
      check("addi_imm", IdExImm, 32'd5);
      IfInstr = i_type(6'h04, 5'd1, 5'd0, 16'd2);
      #1;
      check("brhz_stall_ex", {31'd0, Stall}, 32'd1);
      check("brhz_pcsrc_ex", {31'd0, PCSrc}, 32'd0);
      step();
      MemRegWrite = 1'b1;
      MemWriteReg = 5'd1;
      #1 check("brhz_stall_mem", {31'd0, Stall}, 32'd1);
      step();
      MemRegWrite = 1'b0;
      WbRegWrite  = 1'b1;
      WbWriteReg  = 5'd1;
      WbWriteData = 32'd5;
      #1;
      check("brhz_release", {31'd0, Stall}, 32'd0);
      check("brhz_pcsrc_wb", {31'd0, PCSrc}, 32'd0);
      step();
      WbRegWrite = 1'b0;

      // Jump
      IfPc    = 32'h40000010;
      IfInstr = {6'h02, 26'h0000040};
      #1;
      check("j_target", BranchPC, 32'h40000100);
      check("j_pcsrc", {31'd0, PCSrc}, 32'd1);

      // r0 is never written
      IfInstr     = r_type(5'd0, 5'd0, 5'd9);
      WbRegWrite  = 1'b1;
      WbWriteReg  = 5'd0;
      WbWriteData = 32'h1234;
      step();
      WbRegWrite = 1'b0;
      check("r0_no_bypass", IdExRdData1, 32'd0);
      step();
      check("r0_read", IdExRdData1, 32'd0);

      // Asynchronous reset mid-cycle with live ID/EX contents
      check("prereset_regwrite", {31'd0, IdExRegWrite}, 32'd1);
      #3 Reset_n = 1'b0;
      #1;
      check("async_reset_regwrite", {31'd0, IdExRegWrite}, 32'd0);
      check("async_reset_pc", IdExPc, 32'd0);
      #2 Reset_n = 1'b1;
      IfPc    = 32'h200;
      IfInstr = r_type(5'd5, 5'd0, 5'd9);
      step();
      check("reset_r5", IdExRdData1, 32'd0);

      // Stall beats a taken branch: lw $5,0($0) ; beq $5,$0,1
      IfInstr = i_type(6'h23, 5'd0, 5'd5, 16'd0);
      step();
      IfInstr = i_type(6'h04, 5'd5, 5'd0, 16'd1);
      #1;
      check("prio_stall", {31'd0, Stall}, 32'd1);
      check("prio_pcsrc", {31'd0, PCSrc}, 32'd0);
      check("prio_flush", {31'd0, IfFlush}, 32'd0);
      step();
      check("prio_release_pcsrc", {31'd0, PCSrc}, 32'd1);
      check("prio_target", BranchPC, 32'h208);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
